dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 8, giving a data RAM of 2^DEPTH_LOG2 32-bit words indexed by d_addr[DEPTH_LOG2+1:2].
REQ-002 The block SHALL have parameter WINDOW_HI, default 16'h0000; an access is in-window when d_addr[31:16] == WINDOW_HI.
REQ-003 The block SHALL have port clk, input, 1, the single rising-edge clock.
REQ-004 The block SHALL have port rst_n, input, 1, reset; one clock, reset asynchronous and active-low.
REQ-005 The block SHALL have port d_addr, input, 32, byte address from the core.
REQ-006 The block SHALL have port d_wdata, input, 32, store data, right-aligned for sh and sb.
REQ-007 The block SHALL have port d_we, input, 1, store strobe, sampled each rising edge.
REQ-008 The block SHALL have ports is_sw_i, is_sh_i and is_sb_i, input, 1 each, store size qualifiers, at most one high.
REQ-009 The block SHALL have port d_rdata, output, 32, registered read word.
REQ-010 The block SHALL have port init_busy, output, 1, high while the RAM clear sequence runs.
REQ-011 The block SHALL have port store_cnt, output, 16, count of committed stores.
REQ-012 The block SHALL have port fault, output, 1, sticky misaligned or invalid-store flag.
REQ-013 The block SHALL have port fault_addr, output, 32, d_addr of the first faulting store.

Function
REQ-014 The FSM SHALL have states CLEAR and READY; reset enters CLEAR with clear pointer 0.
REQ-015 In CLEAR, one word per cycle SHALL be written with 0 at the clear pointer; after the last index it SHALL go to READY, taking 2^DEPTH_LOG2 cycles.
REQ-016 init_busy SHALL be 1 exactly while in CLEAR; d_rdata SHALL be 0 and stores SHALL be ignored and uncounted in CLEAR.
REQ-017 In READY, d_rdata SHALL update every edge to RAM[index] if in-window, else 0, so read latency is 1 cycle.
REQ-018 Read-before-write SHALL apply: a load and a store to the same word on the same edge SHALL return the pre-store contents.
REQ-019 A store SHALL commit on an edge with READY, d_we=1, in-window, and a legal size and alignment.
REQ-020 A committed store SHALL merge only its lanes into the old word and leave all other bytes unchanged.
REQ-021 For is_sw_i, all 4 bytes SHALL be written from d_wdata.
REQ-022 For is_sh_i, d_wdata[15:0] SHALL go to bytes [15:0] if d_addr[1]=0, else to bytes [31:16].
REQ-023 For is_sb_i, d_wdata[7:0] SHALL go to byte lane d_addr[1:0].
REQ-024 An illegal store is one with d_we=1 and any of: sw with d_addr[1:0]!=0, sh with d_addr[0]=1, or no size bit or more than one size bit high.
REQ-025 An illegal store SHALL write nothing and SHALL not count.
REQ-026 An illegal store SHALL set fault; fault_addr SHALL be captured only when fault was 0, and later faults SHALL not overwrite it.
REQ-027 An out-of-window store SHALL be silently dropped: no write, no count, no fault.
REQ-028 store_cnt SHALL increment by 1 per committed store and wrap from 16'hFFFF to 0.

Reset
REQ-029 On rst_n low, asynchronously: d_rdata=0, store_cnt=0, fault=0, fault_addr=0, init_busy=1, state=CLEAR, pointer=0.
REQ-030 Reset asserted mid-CLEAR or mid-READY SHALL restart CLEAR from index 0; RAM contents SHALL not be relied on until init_busy falls.
REQ-031 Deasserting rst_n SHALL be synchronous to clk; the first clear write SHALL occur on the first edge with rst_n high.

Verification
REQ-032 Release reset, count cycles -> init_busy high exactly 256 cycles; a d_we during CLEAR leaves RAM and store_cnt unchanged.
REQ-033 Store sw of 32'h00000042 at 0x0, then load 0x0 -> d_rdata=32'h00000042 one edge after the address; store_cnt=1.
REQ-034 Word at 0x4 = 32'hDEADBEEF, then sb of 8'h11 at 0x6 and sh of 16'h2233 at 0x4 -> word reads 32'hDE112233.
REQ-035 sw at 0x1, then sh at 0x3 -> no RAM change, fault=1, fault_addr=0x1, store_cnt unchanged.
REQ-036 sw at 0x00010000 -> no write, no fault; load of 0x00010000 returns 0.
REQ-037 Same-edge store and load to 0x8 -> d_rdata holds the old value, next load returns the new value.

Source files
------------

// File: rtl/dmem_responder.sv
// Single-cycle data memory responder with power-on clear, byte-lane
// store merging, address window filtering and sticky store-fault capture.
module dmem_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [15:0] WINDOW_HI  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_we,
    input  logic        is_sw_i,
    input  logic        is_sh_i,
    input  logic        is_sb_i,
    output logic [31:0] d_rdata,
    output logic        init_busy,
    output logic [15:0] store_cnt,
    output logic        fault,
    output logic [31:0] fault_addr
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                state;
    logic [DEPTH_LOG2-1:0] clr_ptr;
    logic [31:0]           mem [DEPTH];

    logic [DEPTH_LOG2-1:0] idx;
    logic                  in_window;
    logic                  size_ok;
    logic                  align_ok;
    logic                  commit;
    logic                  illegal;
    logic [3:0]            be;
    logic [31:0]           lanes;
    logic [31:0]           mask;
    logic [31:0]           merged;
    logic                  unused_bits;

    assign idx         = d_addr[DEPTH_LOG2+1:2];
    assign in_window   = (d_addr[31:16] == WINDOW_HI);
    assign unused_bits = ^d_addr;

    // Size qualifiers may arrive non-one-hot, so this is a plain case
    always_comb begin
        be       = 4'b0000;
        lanes    = '0;
        size_ok  = 1'b0;
        align_ok = 1'b0;
        case ({is_sw_i, is_sh_i, is_sb_i})
            3'b100: begin
                size_ok  = 1'b1;
                align_ok = (d_addr[1:0] == 2'b00);
                be       = 4'b1111;
                lanes    = d_wdata;
            end
            3'b010: begin
                size_ok  = 1'b1;
                align_ok = ~d_addr[0];
                be       = d_addr[1] ? 4'b1100 : 4'b0011;
                lanes    = {2{d_wdata[15:0]}};
            end
            3'b001: begin
                size_ok  = 1'b1;
                align_ok = 1'b1;
                be       = 4'b0001 << d_addr[1:0];
                lanes    = {4{d_wdata[7:0]}};
            end
            default: ;
        endcase
    end

    assign commit  = (state == READY) && d_we && in_window
                     && size_ok && align_ok;
    assign illegal = (state == READY) && d_we && in_window
                     && !(size_ok && align_ok);

    assign mask = {{8{be[3]}}, {8{be[2]}},
                   {8{be[1]}}, {8{be[0]}}};
    assign merged = (mem[idx] & ~mask) | (lanes & mask);

    // RAM array carries no reset; CLEAR zeroes it word by word
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_ptr] <= '0;
        end else if (commit) begin
            mem[idx] <= merged;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clr_ptr    <= '0;
            d_rdata    <= '0;
            init_busy  <= 1'b1;
            store_cnt  <= '0;
            fault      <= 1'b0;
            fault_addr <= '0;
        end else begin
            unique case (state)
                CLEAR: begin
                    d_rdata <= '0;
                    clr_ptr <= clr_ptr + PTR_ONE;
                    if (&clr_ptr) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                    end
                end
                READY: begin
                    d_rdata <= in_window ? mem[idx] : '0;
                    if (commit) begin
                        store_cnt <= store_cnt + 16'd1;
                    end
                    if (illegal && !fault) begin
                        fault      <= 1'b1;
                        fault_addr <= d_addr;
                    end
                end
            endcase
        end
    end

endmodule
